// File: rtl/seq_detector_fsm.sv
// -----------------------------------------------------------------------------
// seq_detector_fsm
//
// Serial pattern detector. One bit is taken on every posedge where In_Valid is
// high. It is compared against a PAT_LEN-bit pattern that can be reloaded at
// run time. The state is the number of pattern bits matched so far.
//
// The next state is the KMP failure function. It is worked out combinationally
// from the pattern register alone: "the longest prefix of pat that is a suffix
// of (prefix_k, b)". No bit history is stored.
//
// Parameters
//   PAT_LEN  pattern length, 2..8
//   CNT_W    match counter width, 2..16
//   MEALY    1 = Mealy output (same-cycle, combinational)
//            0 = Moore output (extra full-match state, registered decode)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   In_Valid     In_Data is consumed on this edge
//   In_Data      serial data bit
//   Load         load Pattern; wins over In_Valid
//   Pattern      new pattern; MSB is the first bit expected
//   Overlap      1 = overlapping detection, 0 = restart after a match
//   Out_Match    match indication
//   Out_State    number of pattern bits currently matched
//   Match_Count  saturating count of matches since reset / Load
//   Count_Sat    Match_Count is all ones
// -----------------------------------------------------------------------------
module seq_detector_fsm #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8,
    parameter int MEALY   = 1,
    localparam int SW     = $clog2(PAT_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               In_Valid,
    input  logic               In_Data,
    input  logic               Load,
    input  logic [PAT_LEN-1:0] Pattern,
    input  logic               Overlap,
    output logic               Out_Match,
    output logic [SW-1:0]      Out_State,
    output logic [CNT_W-1:0]   Match_Count,
    output logic               Count_Sat
);

    localparam int               PW      = PAT_LEN + 1;
    localparam logic [SW-1:0]    ST_IDLE = {SW{1'b0}};
    localparam logic [SW-1:0]    ST_LAST = SW'(PAT_LEN - 1);
    localparam logic [SW-1:0]    ST_FULL = SW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Find the longest j <= min(k+1, PAT_LEN) for which the first j pattern
    // bits equal the last j bits of {pat[top k bits], b}. Both sequences are
    // right-aligned so that the most recent bit is at bit 0. Each candidate j
    // then becomes a masked compare of the low j bits.
    function automatic logic [SW-1:0] kmp_step(
        input logic [PAT_LEN-1:0] p,
        input logic [SW-1:0]      k,
        input logic               b
    );
        logic [PW-1:0] s;
        logic [PW-1:0] pre;
        logic [PW-1:0] mask;
        logic [SW-1:0] best;
        int            kk;
        kk   = int'(k);
        s    = {p >> (PAT_LEN - kk), b};
        best = ST_IDLE;
        for (int j = 1; j <= PAT_LEN; j++) begin
            pre  = PW'(p >> (PAT_LEN - j));
            mask = ~({PW{1'b1}} << j);
            best = ((j <= kk + 1) && (((s ^ pre) & mask) == {PW{1'b0}})) ? SW'(j) : best;
        end
        return best;
    endfunction

    // Find the longest proper border of the pattern, i.e. the longest prefix
    // that is also a suffix. It is the state to resume from after an
    // overlapping Mealy match.
    function automatic logic [SW-1:0] pat_border(input logic [PAT_LEN-1:0] p);
        logic [PAT_LEN-1:0] pre;
        logic [PAT_LEN-1:0] mask;
        logic [SW-1:0]      best;
        best = ST_IDLE;
        for (int j = 1; j < PAT_LEN; j++) begin
            pre  = p >> (PAT_LEN - j);
            mask = ~({PAT_LEN{1'b1}} << j);
            best = (((p ^ pre) & mask) == {PAT_LEN{1'b0}}) ? SW'(j) : best;
        end
        return best;
    endfunction

    logic [PAT_LEN-1:0] pat_q,   pat_d;
    logic [SW-1:0]      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               sat_q,   sat_d;
    logic [SW-1:0]      from_s;
    logic [SW-1:0]      step_s;
    logic [SW-1:0]      border_s;
    logic               hit_s;
    logic               out_match_s;

    assign border_s = pat_border(pat_q);

    // Compute the next state, pattern and counter. Load wins over In_Valid.
    always_comb begin
        pat_d   = pat_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_s   = 1'b0;
        // Leaving the Moore full state without overlap restarts from state 0.
        // With overlap, state PAT_LEN itself stands for "history = pattern".
        from_s  = ((state_q == ST_FULL) && !Overlap) ? ST_IDLE : state_q;
        step_s  = kmp_step(pat_q, from_s, In_Data);
        if (Load) begin
            pat_d   = Pattern;
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else if (In_Valid) begin
            hit_s = (step_s == ST_FULL);
            if (!hit_s) begin
                state_d = step_s;
            end else if (MEALY == 0) begin
                state_d = ST_FULL;
            end else if (Overlap) begin
                state_d = border_s;
            end else begin
                state_d = ST_IDLE;
            end
            cnt_d = (hit_s && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;
        end else begin
            pat_d   = pat_q;
            state_d = state_q;
            cnt_d   = cnt_q;
        end
        sat_d = (cnt_d == CNT_MAX);
    end

    // State, pattern, counter and saturation flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= {PAT_LEN{1'b0}};
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            sat_q   <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // Match output. The Mealy form looks ahead at the bit being offered now.
    // The Moore form decodes the registered full-match state.
    always_comb begin
        if (MEALY != 0) begin
            out_match_s = In_Valid & ~Load & (state_q == ST_LAST) & (In_Data == pat_q[0]);
        end else begin
            out_match_s = (state_q == ST_FULL);
        end
    end

    assign Out_Match   = out_match_s;
    assign Out_State   = state_q;
    assign Match_Count = cnt_q;
    assign Count_Sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_fsm.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_fsm
//
// Drives three detector builds from shared stimulus:
//   u0: PAT_LEN 4, CNT_W 8, Mealy
//   u1: PAT_LEN 4, CNT_W 8, Moore
//   u2: PAT_LEN 2, CNT_W 2, Mealy (gets the low two pattern bits)
//
// The reference model keeps the recent accepted bits for each build. From
// that history it derives the matched length, the match events and the
// counter.
// -----------------------------------------------------------------------------
module tb_seq_detector_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_data;
    logic       load;
    logic       overlap;
    logic [7:0] pattern;

    logic       m0_match, m1_match, m2_match;
    logic [2:0] m0_state, m1_state;
    logic [1:0] m2_state;
    logic [7:0] m0_cnt, m1_cnt;
    logic [1:0] m2_cnt;
    logic       m0_sat, m1_sat, m2_sat;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, one entry per build.
    logic [7:0] m_hv   [3];
    int         m_hlen [3];
    logic [7:0] m_pat  [3];
    bit         m_full [3];
    int         m_cnt  [3];

    always #5 clk = ~clk;

    seq_detector_fsm #(.PAT_LEN(4), .CNT_W(8), .MEALY(1)) u0 (
        .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Data(in_data), .Load(load),
        .Pattern(pattern[3:0]), .Overlap(overlap), .Out_Match(m0_match),
        .Out_State(m0_state), .Match_Count(m0_cnt), .Count_Sat(m0_sat));

    seq_detector_fsm #(.PAT_LEN(4), .CNT_W(8), .MEALY(0)) u1 (
        .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Data(in_data), .Load(load),
        .Pattern(pattern[3:0]), .Overlap(overlap), .Out_Match(m1_match),
        .Out_State(m1_state), .Match_Count(m1_cnt), .Count_Sat(m1_sat));

    seq_detector_fsm #(.PAT_LEN(2), .CNT_W(2), .MEALY(1)) u2 (
        .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Data(in_data), .Load(load),
        .Pattern(pattern[1:0]), .Overlap(overlap), .Out_Match(m2_match),
        .Out_State(m2_state), .Match_Count(m2_cnt), .Count_Sat(m2_sat));

    function automatic int pl(input int i);
        case (i)
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit is_mealy(input int i);
        case (i)
            1:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int cmax(input int i);
        case (i)
            2:       return 3;
            default: return 255;
        endcase
    endfunction

    function automatic logic [31:0] obs_state(input int i);
        case (i)
            0:       return 32'(m0_state);
            1:       return 32'(m1_state);
            default: return 32'(m2_state);
        endcase
    endfunction

    function automatic logic [31:0] obs_cnt(input int i);
        case (i)
            0:       return 32'(m0_cnt);
            1:       return 32'(m1_cnt);
            default: return 32'(m2_cnt);
        endcase
    endfunction

    function automatic logic [31:0] obs_sat(input int i);
        case (i)
            0:       return 32'(m0_sat);
            1:       return 32'(m1_sat);
            default: return 32'(m2_sat);
        endcase
    endfunction

    // Longest j <= maxj such that the last j history bits equal the first j
    // pattern bits. hv[0] is the most recent bit.
    function automatic int longest(input logic [7:0] hv, input int hl,
                                   input logic [7:0] pt, input int plen, input int maxj);
        int best;
        bit ok;
        best = 0;
        for (int j = 1; j <= maxj; j++) begin
            ok = (j <= hl);
            for (int m = 0; m < j; m++) begin
                if (hv[j-1-m] !== pt[plen-1-m]) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    function automatic int exp_state(input int i);
        if (m_full[i]) return pl(i);
        return longest(m_hv[i], m_hlen[i], m_pat[i], pl(i), pl(i) - 1);
    endfunction

    // Would bit d complete the pattern right now (Mealy look-ahead)?
    function automatic bit peek(input int i, input logic d);
        logic [7:0] hv2;
        int         hl2;
        hv2 = {m_hv[i][6:0], d};
        hl2 = (m_hlen[i] < 8) ? m_hlen[i] + 1 : 8;
        return longest(hv2, hl2, m_pat[i], pl(i), pl(i)) == pl(i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hv[i] = 8'h00; m_hlen[i] = 0; m_pat[i] = 8'h00; m_full[i] = 1'b0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_load(input logic [7:0] pt);
        for (int i = 0; i < 3; i++) begin
            m_pat[i]  = pt & 8'((1 << pl(i)) - 1);
            m_hv[i]   = 8'h00;
            m_hlen[i] = 0;
            m_full[i] = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic model_bit(input logic b, input logic ov);
        bit hit;
        for (int i = 0; i < 3; i++) begin
            if (!is_mealy(i) && m_full[i] && !ov) m_hlen[i] = 0;
            m_hv[i]   = {m_hv[i][6:0], b};
            m_hlen[i] = (m_hlen[i] < 8) ? m_hlen[i] + 1 : 8;
            hit = (longest(m_hv[i], m_hlen[i], m_pat[i], pl(i), pl(i)) == pl(i));
            if (hit) begin
                m_cnt[i] = (m_cnt[i] < cmax(i)) ? m_cnt[i] + 1 : cmax(i);
                if (is_mealy(i) && !ov) m_hlen[i] = 0;
            end
            m_full[i] = !is_mealy(i) && hit;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_state%0d", tag, i), obs_state(i), 32'(exp_state(i)));
            check($sformatf("%s_cnt%0d", tag, i), obs_cnt(i), 32'(m_cnt[i]));
            check($sformatf("%s_sat%0d", tag, i), obs_sat(i), 32'(m_cnt[i] == cmax(i)));
        end
        check($sformatf("%s_moore_out", tag), 32'(m1_match), 32'(m_full[1]));
    endtask

    // One clock cycle. Inputs change at the negedge. The Mealy outputs are
    // checked before the edge; the registered results are checked at the
    // following negedge.
    task automatic step(input logic ld, input logic [7:0] pt, input logic v,
                        input logic d, input logic ov);
        load = ld; pattern = pt; in_valid = v; in_data = d; overlap = ov;
        #1;
        check("mealy_out0", 32'(m0_match), 32'(v & ~ld & peek(0, d)));
        check("mealy_out2", 32'(m2_match), 32'(v & ~ld & peek(2, d)));
        @(posedge clk);
        if (ld) model_load(pt);
        else if (v) model_bit(d, ov);
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic stream(input logic [7:0] bits, input int n, input logic ov);
        for (int k = n - 1; k >= 0; k--) step(1'b0, 8'h00, 1'b1, bits[k], ov);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 1'b0; load = 1'b0; overlap = 1'b0; pattern = 8'h00;
        model_reset();
        #1;
        check_all("reset");
        check("reset_mealy0", 32'(m0_match), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1011, overlapping: stream 1,0,1,1,0,1,1
        step(1'b1, 8'h0B, 1'b0, 1'b0, 1'b1);
        stream(8'b0000_1011, 4, 1'b1);
        check("ov_state_b4", obs_state(0), 32'd1);
        check("moore_state_b4", obs_state(1), 32'd4);
        check("moore_out_b4", 32'(m1_match), 32'd1);
        stream(8'b0000_0011, 3, 1'b1);
        check("ov_cnt", obs_cnt(0), 32'd2);
        check("moore_cnt", obs_cnt(1), 32'd2);

        // 1011, non-overlapping
        step(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
        stream(8'b0000_1011, 4, 1'b0);
        check("nov_state_b4", obs_state(0), 32'd0);
        stream(8'b0000_0011, 3, 1'b0);
        check("nov_cnt", obs_cnt(0), 32'd1);

        // 1101 failure path: 1,1,1,0 then matching 1
        step(1'b1, 8'h0D, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1); check("fail_s1", obs_state(0), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1); check("fail_s2", obs_state(0), 32'd2);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1); check("fail_s3", obs_state(0), 32'd2);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); check("fail_s4", obs_state(0), 32'd3);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1); check("fail_cnt", obs_cnt(0), 32'd1);

        // 1111 / 11 with overlap: six ones, then four more to saturate u2
        step(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1);
        stream(8'b0011_1111, 6, 1'b1);
        check("ones_cnt", obs_cnt(0), 32'd3);
        stream(8'b0000_1111, 4, 1'b1);
        check("sat_cnt", obs_cnt(2), 32'd3);
        check("sat_flag", obs_sat(2), 32'd1);
        step(1'b1, 8'h0F, 1'b1, 1'b1, 1'b1);
        check("load_clr_cnt", obs_cnt(2), 32'd0);
        check("load_clr_sat", obs_sat(2), 32'd0);

        // Asynchronous reset while in state 3 of 1011, with the final bit offered
        step(1'b1, 8'h0B, 1'b0, 1'b0, 1'b1);
        stream(8'b0000_0101, 3, 1'b1);
        check("pre_rst_state", obs_state(0), 32'd3);
        load = 1'b0; in_valid = 1'b1; in_data = 1'b1;
        #1;
        check("pre_rst_mealy", 32'(m0_match), 32'd1);
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_mealy0", 32'(m0_match), 32'd0);
        check("rst_mealy2", 32'(m2_match), 32'd0);
        check_all("async_rst");
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        stream(8'b0000_0000, 4, 1'b1);
        check("zero_pat_cnt", obs_cnt(0), 32'd1);

        // Randomised traffic, including loads colliding with valid data
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 24) == 0), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
